// File: rtl/flippy_pkg.sv
// Shared types and constants for the Flippy Bit falling-byte lanes.
package flippy_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StFall,
    StOver
  } lane_state_e;

  localparam int unsigned ROWS_DEFAULT = 30;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned YPOS_W       = 5;

  // x^8 + x^6 + x^5 + x^4 + 1 expressed as a mask over the shift register bits.
  localparam logic [BYTE_W-1:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/flippy_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; advances every clock and never reaches zero
// as long as the seed is nonzero.
module flippy_lfsr8
  import flippy_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [BYTE_W-1:0] seed_i,
  output logic [BYTE_W-1:0] q_o
);

  logic [BYTE_W-1:0] lfsr_q, lfsr_d;

  // Shift left, feeding back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[BYTE_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // Shift register, reloads the seed on reset.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_q <= seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/flippy_column_lane.sv
// One falling-byte lane: spawns a random nonzero byte, drops it a row per drop
// event and scores a hit when the switches match on fire.
// Optional build macro LANE_SPEEDUP_EN: a saturating hit counter shortens the
// drop interval from every 4th tick down to every tick, one step per 8 hits.
module flippy_column_lane
  import flippy_pkg::*;
#(
  parameter int unsigned       ROWS        = ROWS_DEFAULT,
  parameter int unsigned       SPAWN_DELAY = 4,
  parameter logic [BYTE_W-1:0] LFSR_SEED   = 8'hA5
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              tick_i,
  input  logic              enable_i,
  input  logic [BYTE_W-1:0] user_input_i,
  input  logic              fire_i,
  output logic [BYTE_W-1:0] letter_o,
  output logic [YPOS_W-1:0] ypos_o,
  output logic              active_o,
  output logic              correct_o,
  output logic              game_over_o
);

  localparam logic [YPOS_W-1:0] LastRow  = YPOS_W'(ROWS - 1);
  localparam logic [3:0]        WaitLast = 4'(SPAWN_DELAY - 1);

  lane_state_e       state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [BYTE_W-1:0] letter_q, letter_d;
  logic [YPOS_W-1:0] ypos_q, ypos_d;
  logic              active_q, active_d;
  logic              correct_q, correct_d;
  logic              game_over_q, game_over_d;
  logic [BYTE_W-1:0] lfsr;
  logic              hit;
  logic              drop;

  flippy_lfsr8 u_lfsr (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .seed_i    (LFSR_SEED),
    .q_o       (lfsr)
  );

  assign hit = fire_i && (user_input_i == letter_q);

`ifdef LANE_SPEEDUP_EN
  logic [5:0] hits_q, hits_d;
  logic [1:0] div_q, div_d;
  logic [1:0] div_last;

  // Drop interval minus one: 3 at start, one less per 8 hits, floor 0.
  always_comb begin
    div_last = (hits_q[5:3] >= 3'd3) ? 2'd0 : 2'd3 - hits_q[4:3];
  end

  assign drop = tick_i && (div_q == div_last);

  // Hit counter and tick divider; divider restarts for every new byte.
  always_comb begin
    hits_d = hits_q;
    div_d  = div_q;
    if (!enable_i || state_q == StIdle) begin
      hits_d = '0;
      div_d  = '0;
    end else if (state_q == StFall) begin
      if (hit) begin
        div_d = '0;
        if (hits_q != 6'h3f) hits_d = hits_q + 6'd1;
      end else if (tick_i) begin
        div_d = drop ? 2'd0 : div_q + 2'd1;
      end
    end else begin
      div_d = '0;
    end
  end

  // Speedup state registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hits_q <= '0;
      div_q  <= '0;
    end else begin
      hits_q <= hits_d;
      div_q  <= div_d;
    end
  end
`else
  assign drop = tick_i;
`endif

  // FSM state register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Next-state logic; dropping enable overrides everything.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWait;
        StWait: if (tick_i && wait_q == WaitLast) state_d = StFall;
        StFall: begin
          if (hit)                              state_d = StWait;
          else if (drop && ypos_q == LastRow)   state_d = StOver;
        end
        StOver: state_d = StOver;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output/datapath next values; a hit beats a same-cycle drop.
  always_comb begin
    wait_d      = wait_q;
    letter_d    = letter_q;
    ypos_d      = ypos_q;
    active_d    = active_q;
    correct_d   = 1'b0;
    game_over_d = game_over_q;
    if (!enable_i) begin
      wait_d      = '0;
      letter_d    = '0;
      ypos_d      = '0;
      active_d    = 1'b0;
      game_over_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: wait_d = '0;
        StWait: begin
          if (tick_i) begin
            if (wait_q == WaitLast) begin
              wait_d   = '0;
              letter_d = lfsr;
              ypos_d   = '0;
              active_d = 1'b1;
            end else begin
              wait_d = wait_q + 4'd1;
            end
          end
        end
        StFall: begin
          if (hit) begin
            correct_d = 1'b1;
            letter_d  = '0;
            ypos_d    = '0;
            active_d  = 1'b0;
            wait_d    = '0;
          end else if (drop) begin
            if (ypos_q == LastRow) begin
              game_over_d = 1'b1;
              active_d    = 1'b0;
            end else begin
              ypos_d = ypos_q + 1'b1;
            end
          end
        end
        StOver: ;
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_q      <= '0;
      letter_q    <= '0;
      ypos_q      <= '0;
      active_q    <= 1'b0;
      correct_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      letter_q    <= letter_d;
      ypos_q      <= ypos_d;
      active_q    <= active_d;
      correct_q   <= correct_d;
      game_over_q <= game_over_d;
    end
  end

  assign letter_o    = letter_q;
  assign ypos_o      = ypos_q;
  assign active_o    = active_q;
  assign correct_o   = correct_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_flippy_column_lane.sv
// Self-checking bench for flippy_column_lane: directed scenarios then random play,
// every cycle compared against a behavioural model of the lane.
module tb_flippy_column_lane;

  localparam int unsigned ROWS        = 30;
  localparam int unsigned SPAWN_DELAY = 4;
  localparam logic [7:0]  SEED        = 8'hA5;
`ifdef LANE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
  localparam int P       = 4;
`else
  localparam bit SPEEDUP = 1'b0;
  localparam int P       = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] user_input = 8'h00;
  logic       fire = 1'b0;
  logic [7:0] letter;
  logic [4:0] ypos;
  logic       active;
  logic       correct;
  logic       game_over;

  int n_vec = 0;
  int n_err = 0;

  // Model of the lane in game terms.
  bit         m_run, m_live, m_over, m_correct;
  int         m_waited, m_row, m_hits, m_dticks;
  logic [7:0] m_target, m_lfsr;

  flippy_column_lane #(
    .ROWS        (ROWS),
    .SPAWN_DELAY (SPAWN_DELAY),
    .LFSR_SEED   (SEED)
  ) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .tick_i       (tick),
    .enable_i     (enable),
    .user_input_i (user_input),
    .fire_i       (fire),
    .letter_o     (letter),
    .ypos_o       (ypos),
    .active_o     (active),
    .correct_o    (correct),
    .game_over_o  (game_over)
  );

  always #10 clock = ~clock;

  // x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3, shifted in at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic model_reset();
    m_run = 0; m_live = 0; m_over = 0; m_correct = 0;
    m_waited = 0; m_row = 0; m_hits = 0; m_dticks = 0;
    m_target = 8'h00; m_lfsr = SEED;
  endtask

  task automatic model_step(input logic en, input logic tk, input logic fi,
                            input logic [7:0] ui);
    int period;
    int lvl;
    m_correct = 0;
    if (!en) begin
      m_run = 0; m_live = 0; m_over = 0; m_target = 8'h00; m_row = 0; m_hits = 0;
    end else if (!m_run) begin
      m_run = 1; m_waited = 0;
    end else if (m_over) begin
      // frozen
    end else if (m_live) begin
      if (fi && ui == m_target) begin
        m_correct = 1; m_live = 0; m_target = 8'h00; m_row = 0; m_waited = 0;
        if (m_hits < 63) m_hits++;
      end else if (tk) begin
        lvl = (m_hits / 8 > 3) ? 3 : m_hits / 8;
        period = SPEEDUP ? 4 - lvl : 1;
        m_dticks++;
        if (m_dticks == period) begin
          m_dticks = 0;
          if (m_row == ROWS - 1) begin
            m_over = 1; m_live = 0;
          end else begin
            m_row++;
          end
        end
      end
    end else if (tk) begin
      m_waited++;
      if (m_waited == SPAWN_DELAY) begin
        m_live = 1; m_target = m_lfsr; m_row = 0; m_dticks = 0;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("letter", letter, m_target);
    chk("ypos", 8'(ypos), 8'(m_row));
    chk("active", 8'(active), 8'(m_live));
    chk("correct", 8'(correct), 8'(m_correct));
    chk("game_over", 8'(game_over), 8'(m_over));
  endtask

  task automatic step(input logic en, input logic tk, input logic fi, input logic [7:0] ui);
    enable = en; tick = tk; fire = fi; user_input = ui;
    @(posedge clock);
    model_step(en, tk, fi, ui);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    #5;
    chk("reset letter", letter, 8'h00);
    chk("reset ypos", 8'(ypos), 8'h00);
    chk("reset flags", {5'b0, active, correct, game_over}, 8'h00);
    #20 reset_n = 1'b1;

    // 1: spawn after 4 ticks
    step(1'b1, 1'b0, 1'b0, 8'h00);
    ticks(4);
    chk("t1 active", 8'(active), 8'h01);
    chk("t1 ypos", 8'(ypos), 8'h00);
    chk("t1 letter nonzero", 8'(letter != 8'h00), 8'h01);

    // 2: fall to the bottom, then one more drop ends the game
    ticks(29 * P);
    chk("t2 ypos bottom", 8'(ypos), 8'd29);
    chk("t2 not over yet", 8'(game_over), 8'h00);
    ticks(P);
    chk("t2 game_over", 8'(game_over), 8'h01);
    chk("t2 ypos held", 8'(ypos), 8'd29);
    ticks(3);
    chk("t2 ypos frozen", 8'(ypos), 8'd29);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t2 cleared", {letter, 3'b0, ypos}, 16'h0000);

    // 3: hit at row 5, then respawn
    step(1'b1, 1'b0, 1'b0, 8'h00);
    ticks(4);
    ticks(5 * P);
    chk("t3 ypos5", 8'(ypos), 8'd5);
    step(1'b1, 1'b0, 1'b1, m_target);
    chk("t3 correct", 8'(correct), 8'h01);
    chk("t3 inactive", 8'(active), 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t3 correct pulse", 8'(correct), 8'h00);
    ticks(4);
    chk("t3 respawn active", 8'(active), 8'h01);
    chk("t3 respawn ypos", 8'(ypos), 8'h00);

    // 4: mismatched fire is ignored
    ticks(P - 1);
    step(1'b1, 1'b1, 1'b1, m_target ^ 8'h01);
    chk("t4 no correct", 8'(correct), 8'h00);
    chk("t4 ypos advanced", 8'(ypos), 8'd1);

    // 5: hit coinciding with the final drop
    ticks(28 * P + P - 1);
    chk("t5 ypos bottom", 8'(ypos), 8'd29);
    step(1'b1, 1'b1, 1'b1, m_target);
    chk("t5 correct", 8'(correct), 8'h01);
    chk("t5 no game_over", 8'(game_over), 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t5 still no game_over", 8'(game_over), 8'h00);

    // 6: drop cadence before and after 8 hits, then async reset mid-fall
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    ticks(4);
    ticks(3);
    chk("t6 slow 3 ticks", 8'(ypos), SPEEDUP ? 8'd0 : 8'd3);
    ticks(1);
    chk("t6 slow 4 ticks", 8'(ypos), SPEEDUP ? 8'd1 : 8'd4);
    for (int h = 0; h < 8; h++) begin
      step(1'b1, 1'b0, 1'b1, m_target);
      ticks(4);
    end
    ticks(2);
    chk("t6 fast 2 ticks", 8'(ypos), SPEEDUP ? 8'd0 : 8'd2);
    ticks(1);
    chk("t6 fast 3 ticks", 8'(ypos), SPEEDUP ? 8'd1 : 8'd3);
    ticks(6);
    reset_n = 1'b0;
    model_reset();
    #2;
    check_all();
    #2 reset_n = 1'b1;

    // random play
    for (int i = 0; i < 1500; i++) begin
      logic en_r, tk_r, fi_r;
      logic [7:0] ui_r;
      en_r = ($urandom_range(0, 99) != 0);
      tk_r = ($urandom_range(0, 2) == 0);
      fi_r = ($urandom_range(0, 3) == 0);
      ui_r = $urandom_range(0, 1) ? m_target : 8'($urandom);
      if ($urandom_range(0, 7) == 0) ui_r = m_target ^ (8'h01 << $urandom_range(0, 7));
      step(en_r, tk_r, fi_r, ui_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
